fpu_mac_seq: RTL
================

Name: fpu_mac_seq

Overview:
Sequencing initiator for the combinational bfloat16 FPU port. It drives op/in1/in2 into the FPU and captures out/overflow.
It accepts a stream of operand pairs over a valid/ready handshake. For each pair it issues one MUL, then one ADD into a running accumulator, producing a bfloat16 dot product.
It sits between a vector feeder and the FPU, and converts the purely combinational FPU into a clocked, handshaked MAC engine.

Parameters:
DATA_WIDTH, 16, operand/result width (bfloat16: 1 sign, 8 exp, 7 frac)
CNT_WIDTH, 8, width of element counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid_i  in  1  operand pair valid
in_ready_o  out  1  operand pair accepted when valid&ready
a_i  in  DATA_WIDTH  operand A (bfloat16)
b_i  in  DATA_WIDTH  operand B (bfloat16)
last_i  in  1  marks final pair of a vector
res_valid_o  out  1  result available
res_ready_i  in  1  result consumed when valid&ready
res_o  out  DATA_WIDTH  accumulated dot product
res_ovf_o  out  1  sticky overflow for this vector
res_cnt_o  out  CNT_WIDTH  number of pairs accumulated (saturating)
fpu_op_o  out  MODE_WIDTH  FPU operation select
fpu_in1_o  out  DATA_WIDTH  FPU operand 1
fpu_in2_o  out  DATA_WIDTH  FPU operand 2
fpu_out_i  in  DATA_WIDTH  FPU result (combinational, same cycle)
fpu_overflow_i  in  1  FPU overflow flag (same cycle)

Behaviour:
- Single clock domain: clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: state=IDLE; in_ready_o=0; res_valid_o=0; res_o=16'h0000; res_ovf_o=0; res_cnt_o=0. Internal acc=16'h0000, a_q/b_q/prod_q=0, last_q=0. fpu_op_o=MODE_ADD, fpu_in1_o=0, fpu_in2_o=0.
- FSM states: IDLE, MUL, ADD, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i: register a_i, b_i, last_i, then go to MUL.
  - FPU driven with MODE_ADD, 0, 0.
- MUL:
  - in_ready_o=0. Drive fpu_op_o=MODE_MUL, in1=a_q, in2=b_q.
  - Capture fpu_out_i into prod_q at clock edge; ovf_q |= fpu_overflow_i. Go to ADD.
- ADD:
  - Drive fpu_op_o=MODE_ADD, in1=acc, in2=prod_q.
  - Capture fpu_out_i into acc; ovf_q |= fpu_overflow_i.
  - cnt += 1, saturating at 2^CNT_WIDTH-1 with no wrap.
  - If last_q, go to DONE; else go to IDLE.
- DONE:
  - res_valid_o=1; res_o=acc, res_cnt_o=cnt, res_ovf_o=ovf_q, all stable while valid.
  - On res_ready_i: clear acc to 16'h0000, ovf_q=0, cnt=0, then go to IDLE. res_valid_o drops next cycle.
- Throughput: 3 cycles per pair (IDLE accept, MUL, ADD). Minimum result latency after the last pair is accepted is 2 cycles to res_valid_o.
- The FPU is combinational. All FPU outputs are sampled in the same cycle the operands are driven; no FPU pipeline is assumed.
- Accumulator starts at +0, so a first ADD returns the product unchanged.
- Overflow: sticky per vector. Never cleared before the result handshake.
- in_valid_i held while not in IDLE: ignored; the pair is accepted on the next IDLE cycle.
- res_ready_i high before DONE: no effect.
- Reset mid-operation: immediately returns to IDLE with the reset values above; the partial vector is discarded.
- Handshake rules: no combinational path from in_valid_i to in_ready_o, nor from res_ready_i to res_valid_o.

Decomposition:
- data_type_pkg holds DATA_WIDTH, MODE_WIDTH, the operation encodings MODE_ADD/MODE_MUL, and the FSM state enum mac_state_e.
- No sub-module: single FSM plus datapath registers.
- Verification top instantiates fpu_mac_seq with the existing fpu, wired port-to-port.

Test Plan:
- Single pair a=0x3F80 (1.0), b=0x4000 (2.0), last=1 -> res_o=0x4000, res_cnt_o=1, res_ovf_o=0, res_valid_o 2 cycles after accept.
- Vector [0x3F80,0x4000]·[0x4000,0x4040] (1·2 + 2·3) -> res_o=0x4100 (8.0), res_cnt_o=2.
- Overflow: a=0x7F00, b=0x7F00, then a=0x3F80, b=0x3F80, last -> res_ovf_o=1 (sticky through second pair), cnt=2.
- Backpressure: hold res_ready_i=0 for 5 cycles in DONE -> res_valid_o/res_o stable, in_ready_o=0. Next vector 0x3F00·0x4000 -> res_o=0x3F80, proving acc was cleared.
- Reset mid-vector: assert rst_n=0 during ADD of the second pair -> all outputs at reset values asynchronously. A fresh vector 0x4000·0x4000 -> res_o=0x4080, cnt=1.
- Saturation: CNT_WIDTH=2, 5 pairs of 0x0000·0x0000 -> res_cnt_o=3, res_o=0x0000.

Source files
------------

// File: rtl/data_type_pkg.sv
// rtl/data_type_pkg.sv - bfloat16 widths, FPU operation encodings and MAC sequencer state type
package data_type_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int MODE_WIDTH = 2;

    localparam logic [MODE_WIDTH-1:0] MODE_ADD = 2'd0;
    localparam logic [MODE_WIDTH-1:0] MODE_MUL = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } mac_state_e;

endpackage

// File: rtl/fpu_mac_seq.sv
// rtl/fpu_mac_seq.sv - sequences a combinational bfloat16 FPU into a handshaked multiply-accumulate engine
module fpu_mac_seq
    import data_type_pkg::*;
#(
    parameter int DATA_WIDTH = data_type_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  last_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [DATA_WIDTH-1:0] res_o,
    output logic                  res_ovf_o,
    output logic [CNT_WIDTH-1:0]  res_cnt_o,
    output logic [MODE_WIDTH-1:0] fpu_op_o,
    output logic [DATA_WIDTH-1:0] fpu_in1_o,
    output logic [DATA_WIDTH-1:0] fpu_in2_o,
    input  logic [DATA_WIDTH-1:0] fpu_out_i,
    input  logic                  fpu_overflow_i
);

    mac_state_e            r_state;
    mac_state_e            w_next;
    logic                  r_in_ready;
    logic                  r_res_valid;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_last;
    logic [DATA_WIDTH-1:0] r_prod;
    logic [DATA_WIDTH-1:0] r_acc;
    logic                  r_ovf;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  w_accept;

    assign w_accept    = (r_state == S_IDLE) && in_valid_i && r_in_ready;
    assign in_ready_o  = r_in_ready;
    assign res_valid_o = r_res_valid;
    assign res_o       = r_acc;
    assign res_ovf_o   = r_ovf;
    assign res_cnt_o   = r_cnt;

    always_comb begin
        w_next    = r_state;
        fpu_op_o  = MODE_ADD;
        fpu_in1_o = '0;
        fpu_in2_o = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_MUL;
            end
            S_MUL: begin
                fpu_op_o  = MODE_MUL;
                fpu_in1_o = r_a;
                fpu_in2_o = r_b;
                w_next    = S_ADD;
            end
            S_ADD: begin
                fpu_op_o  = MODE_ADD;
                fpu_in1_o = r_acc;
                fpu_in2_o = r_prod;
                w_next    = r_last ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                if (res_ready_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so neither ready nor valid
    // depends combinationally on the partner's strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next == S_IDLE);
            r_res_valid <= (w_next == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_last <= 1'b0;
            r_prod <= '0;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a    <= a_i;
                        r_b    <= b_i;
                        r_last <= last_i;
                    end
                end
                S_MUL: begin
                    r_prod <= fpu_out_i;
                    r_ovf  <= r_ovf | fpu_overflow_i;
                end
                S_ADD: begin
                    r_acc <= fpu_out_i;
                    r_ovf <= r_ovf | fpu_overflow_i;
                    if (r_cnt != {CNT_WIDTH{1'b1}}) r_cnt <= r_cnt + 1'b1;
                end
                S_DONE: begin
                    if (res_ready_i) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
